// File: rtl/segled_status_driver.sv
// Serial 7-segment status display driver: encodes {game, health, score} into an
// 8-digit frame and shifts it out MSB-first. Optional seg_pen blink: SEGLED_BLINK_EN.
//
// state   | meaning
// --------+-----------------------------------------------------------
// S_IDLE  | waiting for an input change, first frame or refresh timeout
// S_LOAD  | snapshot encoded into the frame vector, bit index set to 63
// S_SETUP | seg_clk low, seg_do holds the current bit
// S_HIGH  | seg_clk high, chain samples seg_do
// S_DONE  | frame finished, sent snapshot updated, display enabled
module segled_status_driver #(
   parameter int CLK_DIV        = 4,
`ifdef SEGLED_BLINK_EN
   parameter int BLINK_LOG2     = 25,
`endif
   parameter int REFRESH_CYCLES = 1000000
) (
   input  logic       clk,
   input  logic       rstn,
   input  logic [3:0] score,
   input  logic [3:0] health,
   input  logic [1:0] game,
   output logic       seg_clk,
   output logic       seg_clr,
   output logic       seg_do,
   output logic       seg_pen,
   output logic       busy
);

   localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam int RW = (REFRESH_CYCLES > 0) ? $clog2(REFRESH_CYCLES + 1) : 1;
   localparam logic [DW-1:0] DIV_LOAD = DW'(CLK_DIV - 1);
   localparam logic [RW-1:0] REF_MAX  = RW'(REFRESH_CYCLES);
   localparam logic [7:0]    SEG_BLANK = 8'hFF;

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_LOAD  = 3'd1,
      S_SETUP = 3'd2,
      S_HIGH  = 3'd3,
      S_DONE  = 3'd4
   } state_t;

   state_t          r_state;
   state_t          w_state_nxt;
   logic [9:0]      r_snap;
   logic [9:0]      r_sent;
   logic            r_sent_vld;
   logic [62:0]     r_shift;
   logic [5:0]      r_bit_idx;
   logic [DW-1:0]   r_div_cnt;
   logic [RW-1:0]   r_refresh_cnt;
   logic            r_seg_clk;
   logic            r_seg_clr;
   logic            r_seg_do;
   logic            r_seg_pen;

   logic [9:0]      w_live;
   logic [63:0]     w_frame;
   logic [RW-1:0]   w_refresh_inc;
   logic            w_refresh_hit;
   logic            w_div_tc;
   logic            w_start;

   // Segment byte {dp,g,f,e,d,c,b,a}, active-low.
   function automatic logic [7:0] f_hex(input logic [3:0] v);
      logic [7:0] seg;
      case (v)
         4'h0:    seg = 8'hC0;
         4'h1:    seg = 8'hF9;
         4'h2:    seg = 8'hA4;
         4'h3:    seg = 8'hB0;
         4'h4:    seg = 8'h99;
         4'h5:    seg = 8'h92;
         4'h6:    seg = 8'h82;
         4'h7:    seg = 8'hF8;
         4'h8:    seg = 8'h80;
         4'h9:    seg = 8'h90;
         4'hA:    seg = 8'h88;
         4'hB:    seg = 8'h83;
         4'hC:    seg = 8'hC6;
         4'hD:    seg = 8'hA1;
         4'hE:    seg = 8'h86;
         default: seg = 8'h8E;
      endcase
      return seg;
   endfunction

   function automatic logic [7:0] f_glyph(input logic [1:0] g);
      logic [7:0] seg;
      case (g)
         2'b00:   seg = 8'hBF;
         2'b01:   seg = SEG_BLANK;
         2'b11:   seg = 8'hC1;
         default: seg = 8'hC7;
      endcase
      return seg;
   endfunction

   assign w_live  = {game, health, score};
   assign w_frame = {f_glyph(r_snap[9:8]), SEG_BLANK, SEG_BLANK, f_hex(r_snap[7:4]),
                     SEG_BLANK, SEG_BLANK, SEG_BLANK, f_hex(r_snap[3:0])};

   assign w_div_tc      = (r_div_cnt == '0);
   assign w_refresh_inc = (r_refresh_cnt == REF_MAX) ? r_refresh_cnt : r_refresh_cnt + 1'b1;
   // Hit on the IDLE cycle that brings the count to REFRESH_CYCLES, so exactly
   // REFRESH_CYCLES idle cycles separate DONE from the next LOAD.
   assign w_refresh_hit = (REFRESH_CYCLES != 0) && (w_refresh_inc == REF_MAX);
   assign w_start       = !r_sent_vld || (w_live != r_sent) || w_refresh_hit;

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE:  if (w_start) w_state_nxt = S_LOAD;
         S_LOAD:  w_state_nxt = S_SETUP;
         S_SETUP: if (w_div_tc) w_state_nxt = S_HIGH;
         S_HIGH:  if (w_div_tc) w_state_nxt = (r_bit_idx == '0) ? S_DONE : S_SETUP;
         S_DONE:  w_state_nxt = S_IDLE;
         default: w_state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_state       <= S_IDLE;
         r_snap        <= '0;
         r_sent        <= '0;
         r_sent_vld    <= 1'b0;
         r_shift       <= '0;
         r_bit_idx     <= '0;
         r_div_cnt     <= '0;
         r_refresh_cnt <= '0;
         r_seg_clk     <= 1'b0;
         r_seg_clr     <= 1'b0;
         r_seg_do      <= 1'b0;
      end else begin
         r_state   <= w_state_nxt;
         r_seg_clr <= 1'b1;
         r_seg_clk <= (w_state_nxt == S_HIGH);
         // Snapshot is taken on the edge into LOAD so the frame encodes
         // exactly the value that triggered it; LOAD then encodes from the register.
         if ((r_state == S_IDLE) && (w_state_nxt == S_LOAD)) r_snap <= w_live;
         case (r_state)
            S_IDLE: r_refresh_cnt <= w_refresh_inc;
            S_LOAD: begin
               r_shift       <= w_frame[62:0];
               r_seg_do      <= w_frame[63];
               r_bit_idx     <= 6'd63;
               r_div_cnt     <= DIV_LOAD;
               r_refresh_cnt <= '0;
            end
            S_SETUP: r_div_cnt <= w_div_tc ? DIV_LOAD : r_div_cnt - 1'b1;
            S_HIGH: begin
               if (w_div_tc) begin
                  r_div_cnt <= DIV_LOAD;
                  r_shift   <= {r_shift[61:0], 1'b0};
                  if (r_bit_idx != '0) begin
                     r_bit_idx <= r_bit_idx - 1'b1;
                     r_seg_do  <= r_shift[62];
                  end
               end else begin
                  r_div_cnt <= r_div_cnt - 1'b1;
               end
            end
            S_DONE: begin
               r_sent     <= r_snap;
               r_sent_vld <= 1'b1;
            end
            default: ;
         endcase
      end
   end

`ifdef SEGLED_BLINK_EN
   logic [BLINK_LOG2-1:0] r_blink_cnt;
   logic                  w_blink_cond;
   logic                  w_blink_tc;

   assign w_blink_cond = r_sent_vld && ((r_sent[9:8] == 2'b10) || (r_sent[7:4] == 4'h0));
   assign w_blink_tc   = &r_blink_cnt;

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_blink_cnt <= '0;
         r_seg_pen   <= 1'b0;
      end else begin
         r_blink_cnt <= r_blink_cnt + 1'b1;
         if (w_blink_cond) begin
            if (w_blink_tc) r_seg_pen <= ~r_seg_pen;
         end else if (r_sent_vld || (w_state_nxt == S_DONE)) begin
            r_seg_pen <= 1'b1;
         end
      end
   end
`else
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn)                       r_seg_pen <= 1'b0;
      else if (w_state_nxt == S_DONE)  r_seg_pen <= 1'b1;
   end
`endif

   assign seg_clk = r_seg_clk;
   assign seg_clr = r_seg_clr;
   assign seg_do  = r_seg_do;
   assign seg_pen = r_seg_pen;
   assign busy    = (r_state != S_IDLE);

endmodule

// File: tb/tb_segled_status_driver.sv
// Bench for segled_status_driver: decodes the serial stream into frames and
// compares against a font-table model of the display contents.
module tb_segled_status_driver;

   localparam int CLK_DIV = 2;
   localparam int REFRESH = 1000;
   localparam int FLEN    = 2 + 64 * 2 * CLK_DIV;

   localparam logic [7:0] FONT [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                                        8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};

   logic       clk = 1'b0;
   logic       rstn;
   logic [3:0] score;
   logic [3:0] health;
   logic [1:0] game;
   logic       seg_clk, seg_clr, seg_do, seg_pen, busy;
   logic       seg_clk0, seg_clr0, seg_do0, seg_pen0, busy0;

   int checks   = 0;
   int failures = 0;

   segled_status_driver #(.CLK_DIV(CLK_DIV), .REFRESH_CYCLES(REFRESH)) dut (
      .clk(clk), .rstn(rstn), .score(score), .health(health), .game(game),
      .seg_clk(seg_clk), .seg_clr(seg_clr), .seg_do(seg_do), .seg_pen(seg_pen), .busy(busy));

   segled_status_driver #(.CLK_DIV(3), .REFRESH_CYCLES(0)) dut0 (
      .clk(clk), .rstn(rstn), .score(score), .health(health), .game(game),
      .seg_clk(seg_clk0), .seg_clr(seg_clr0), .seg_do(seg_do0), .seg_pen(seg_pen0), .busy(busy0));

   always #5 clk = ~clk;

   function automatic logic [63:0] model(input logic [1:0] g, input logic [3:0] h, input logic [3:0] s);
      logic [7:0] glyph;
      case (g)
         2'b00:   glyph = 8'hBF;
         2'b01:   glyph = 8'hFF;
         2'b11:   glyph = 8'hC1;
         default: glyph = 8'hC7;
      endcase
      return {glyph, 16'hFFFF, FONT[h], 24'hFFFFFF, FONT[s]};
   endfunction

   // Stream monitor, sampled on the falling clk edge.
   int          smp = 0, run = 0, nbits = 0, busy_run = 0, idle_run = 0;
   int          last_nbits = 0, last_busy_len = 0, last_idle_run = 0, done_cnt = 0;
   int          phase_err = 0, do_viol = 0, last_rise = -100, last_chg = -100;
   bit          first_low = 1'b0, p_clk = 1'b0, p_busy = 1'b0, p_do = 1'b0;
   logic [63:0] cap = '0, last_frame = '0;
   logic        pen_first = 1'b0, pen_done = 1'b0;

   always @(negedge clk) begin
      smp++;
      if (busy) begin
         if (!p_busy) begin
            nbits = 0; cap = '0; busy_run = 0; run = 1; first_low = 1'b1;
            last_idle_run = idle_run;
         end else if (seg_clk == p_clk) begin
            run++;
         end else begin
            if (seg_clk) begin
               if (run != (first_low ? CLK_DIV + 1 : CLK_DIV)) phase_err++;
               first_low = 1'b0;
               cap = {cap[62:0], seg_do};
               nbits++;
               if (nbits == 1) pen_first = seg_pen;
               if (smp - last_chg < 2) do_viol++;
               last_rise = smp;
            end else if (run != CLK_DIV) begin
               phase_err++;
            end
            run = 1;
         end
         if (p_busy && (seg_do != p_do)) begin
            if (smp - last_rise < 2) do_viol++;
            last_chg = smp;
         end
         if (!seg_clk && nbits == 64) pen_done = seg_pen;
         busy_run++;
      end else begin
         if (p_busy) begin
            done_cnt++; last_frame = cap; last_nbits = nbits; last_busy_len = busy_run;
         end
         idle_run = p_busy ? 1 : idle_run + 1;
      end
      p_clk = seg_clk; p_busy = busy; p_do = seg_do;
   end

   int f0_starts = 0, f0_run = 0, f0_last_len = 0;
   bit p_busy0 = 1'b0;
   always @(negedge clk) begin
      if (busy0 && !p_busy0) begin f0_starts++; f0_run = 0; end
      if (busy0) f0_run++;
      else if (p_busy0) f0_last_len = f0_run;
      p_busy0 = busy0;
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic wait_done(input string tag, input int budget);
      int start, n;
      start = done_cnt;
      n = 0;
      while (done_cnt == start && n < budget) begin @(negedge clk); #1; n++; end
      chk({tag, "_timeout"}, 64'(done_cnt != start), 64'd1);
   endtask

   task automatic wait_bits(input string tag, input int nb, input int budget);
      int n;
      n = 0;
      while (!(busy && nbits >= nb) && n < budget) begin @(negedge clk); #1; n++; end
      chk({tag, "_timeout"}, 64'(busy && nbits >= nb), 64'd1);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   initial begin
      int pen_low;
      int s0;
      logic [3:0] rs, rh;
      logic [1:0] rg;

      rstn = 1'b0; score = 4'd3; health = 4'd5; game = 2'b01;
      repeat (3) @(negedge clk);
      #1;
      chk("rst_seg_clk", 64'(seg_clk), 64'd0);
      chk("rst_seg_clr", 64'(seg_clr), 64'd0);
      chk("rst_seg_do",  64'(seg_do),  64'd0);
      chk("rst_seg_pen", 64'(seg_pen), 64'd0);
      chk("rst_busy",    64'(busy),    64'd0);

      rstn = 1'b1;
      #1 chk("clr_before_edge", 64'(seg_clr), 64'd0);
      @(negedge clk); #1;
      chk("clr_after_edge", 64'(seg_clr), 64'd1);

      wait_done("frame1", 400);
      chk("frame1_bits",   last_frame, 64'hFFFF_FF92_FFFF_FFB0);
      chk("frame1_nbits",  64'(last_nbits), 64'd64);
      chk("frame1_busy",   64'(last_busy_len), 64'd258);
      chk("frame1_pen_mid", 64'(pen_first), 64'd0);
      chk("frame1_pen_done", 64'(pen_done), 64'd1);

      wait_done("refresh", REFRESH + 400);
      chk("refresh_gap",  64'(last_idle_run), 64'(REFRESH));
      chk("refresh_bits", last_frame, 64'hFFFF_FF92_FFFF_FFB0);

      for (int i = 0; i < 6; i++) begin
         repeat ($urandom_range(0, 20)) @(negedge clk);
         #1;
         rs = 4'($urandom_range(0, 15));
         rh = 4'($urandom_range(0, 15));
         rg = 2'($urandom_range(0, 3));
         score = rs; health = rh; game = rg;
         wait_done("rand", REFRESH + 600);
         chk("rand_frame", last_frame, model(rg, rh, rs));
         chk("rand_busy",  64'(last_busy_len), 64'(FLEN));
      end

      score = 4'd3; health = 4'd5; game = 2'b01;
      wait_bits("mid", 34, REFRESH + 600);
      score = 4'd9;
      wait_done("mid_cur", 400);
      chk("mid_cur_frame", last_frame, model(2'b01, 4'd5, 4'd3));
      chk("mid_cur_last",  64'(last_frame[7:0]), 64'hB0);
      wait_done("mid_next", 400);
      chk("mid_next_gap",   64'(last_idle_run), 64'd1);
      chk("mid_next_frame", last_frame, model(2'b01, 4'd5, 4'd9));
      chk("mid_next_last",  64'(last_frame[7:0]), 64'h90);

      score = 4'hA; health = 4'hC; game = 2'b00;
      wait_bits("abort", 24, 600);
      #2 rstn = 1'b0;
      #1;
      chk("abort_seg_clk", 64'(seg_clk), 64'd0);
      chk("abort_seg_clr", 64'(seg_clr), 64'd0);
      chk("abort_seg_do",  64'(seg_do),  64'd0);
      chk("abort_seg_pen", 64'(seg_pen), 64'd0);
      chk("abort_busy",    64'(busy),    64'd0);
      repeat (2) @(negedge clk);
      #1 rstn = 1'b1;
      wait_done("after_abort", 400);
      chk("after_abort_nbits", 64'(last_nbits), 64'd64);
      chk("after_abort_frame", last_frame, model(2'b00, 4'hC, 4'hA));
      chk("after_abort_busy",  64'(last_busy_len), 64'(FLEN));
      chk("after_abort_pen",   64'(pen_first), 64'd0);

      rs = 4'($urandom_range(0, 15));
      score = rs; health = 4'd0; game = 2'b10;
      wait_done("lose", REFRESH + 600);
      chk("lose_frame", last_frame, model(2'b10, 4'd0, rs));
      chk("lose_glyph", 64'(last_frame[63:56]), 64'hC7);
      pen_low = 0;
      repeat (100) begin @(negedge clk); if (seg_pen !== 1'b1) pen_low++; end
      #1 chk("lose_pen_steady", 64'(pen_low), 64'd0);

      s0 = 0;
      while (busy0 && s0 < 1000) begin @(negedge clk); s0++; end
      #1;
      s0 = f0_starts;
      repeat (2500) @(negedge clk);
      #1;
      chk("norefresh_frames", 64'(f0_starts), 64'(s0));
      chk("norefresh_len",    64'(f0_last_len), 64'(2 + 64 * 2 * 3));

      chk("phase_lengths", 64'(phase_err), 64'd0);
      chk("do_stability",  64'(do_viol),   64'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/segled_status_driver.md
Name: segled_status_driver

Overview:
- Serial 7-segment status display driver; sits downstream of the score, health and game-state logic in the top level.
- Drives the board's four-wire serial LED chain (SEGLED_Clk, SEGLED_CLR, SEGLED_DO, SEGLED_PEN), which is unused at present.
- Snapshots {game, health, score}, encodes 8 digits × 8 segments into 64 bits and shifts them out MSB-first on a divided serial clock.
- Re-sends a frame on any input change and periodically thereafter.

Parameters:
- CLK_DIV, 4: clk cycles per serial-clock phase (low phase and high phase each); minimum 1.
- REFRESH_CYCLES, 1000000: idle clk cycles after a frame before an unforced re-send; 0 disables periodic refresh.
- BLINK_LOG2, 25: blink half-period is 2^BLINK_LOG2 clk cycles; used only with the optional feature.

Ports:
- clk  in  1  system clock (100 MHz)
- rstn  in  1  asynchronous active-low reset
- score  in  4  snowflake score, shown as one hex digit
- health  in  4  player health, shown as one hex digit
- game  in  2  game state: 00 begin, 01 playing, 11 win, 10 lose
- seg_clk  out  1  serial shift clock; the chain samples on the rising edge
- seg_clr  out  1  active-low chain clear
- seg_do  out  1  serial data
- seg_pen  out  1  display enable, active high
- busy  out  1  high while a frame is in progress

Behaviour:
- Reset (asynchronous, immediate): seg_clk=0, seg_do=0, seg_clr=0, seg_pen=0, busy=0, state=IDLE, sent-valid=0, all counters 0.
- seg_clr is registered: it goes to 1 on the first clk edge after rstn deasserts.
- Segment byte is {dp,g,f,e,d,c,b,a}, active-low.
- Hex font:
  - 0..7: C0 F9 A4 B0 99 92 82 F8
  - 8..F: 80 90 88 83 C6 A1 86 8E
  - blank: FF
- Frame order, first shifted to last: d7 = game glyph, d6..d5 = FF, d4 = hex(health), d3..d1 = FF, d0 = hex(score).
- Game glyph: 00→BF ('-'), 01→FF, 11→C1 ('U'), 10→C7 ('L').
- Each byte is sent dp-first; 64 bits total.
- FSM:
  - IDLE: start a frame when sent-valid=0, or the current {game,health,score} differs from the sent snapshot, or (REFRESH_CYCLES≠0 and the refresh counter reaches REFRESH_CYCLES). Start means going to LOAD on the next edge.
  - LOAD (1 cycle): capture snapshot, build the 64-bit vector, set the bit index to 63, clear the refresh counter.
  - SETUP (CLK_DIV cycles): seg_clk=0, seg_do=current MSB.
  - HIGH (CLK_DIV cycles): seg_clk=1, seg_do held. On exit, shift left; if the index is 0 go to DONE, else decrement and return to SETUP.
  - DONE (1 cycle): seg_clk=0, seg_pen←1 (stays 1 until reset), sent snapshot ← captured snapshot, sent-valid←1, then IDLE.
- Frame latency: LOAD to return to IDLE = 2 + 64·2·CLK_DIV cycles.
- busy = (state≠IDLE).
- seg_do changes only while entering SETUP, so data is stable for a full phase on either side of each rising edge.
- Input changes during a frame do not alter the frame in flight. The comparison in IDLE against the sent snapshot triggers a new frame on the first IDLE cycle.
- Refresh counter counts only in IDLE and saturates at REFRESH_CYCLES.
- Reset mid-frame aborts immediately. After release a full new frame is sent, because sent-valid=0.
- Glyph encoding is combinational from the snapshot register, never from live inputs.

Optional Feature:
- Macro: SEGLED_BLINK_EN.
- Defined: after the first frame, while the captured game==10 or health==0, seg_pen toggles every 2^BLINK_LOG2 clk cycles from a free-running counter. When the condition clears, seg_pen returns to 1 on the next edge.
- Undefined: no blink counter is built; seg_pen stays 1 after the first frame.

Test Plan:
- Reset release, CLK_DIV=2, score=3, health=5, game=01 → seg_clr=1 one cycle after release. Bytes sampled on 64 seg_clk rising edges: FF FF FF 92 FF FF FF B0. seg_pen rises in DONE; busy is high for exactly 258 cycles.
- Same frame → every seg_clk high and low phase is 2 cycles, and seg_do never changes on or adjacent to a rising edge.
- score 3→9 at bit 30 of a frame → current frame still ends with B0. The next frame starts 1 cycle after IDLE is entered and ends with 90.
- Stable inputs, REFRESH_CYCLES=1000 → new LOAD 1000 IDLE cycles after each DONE. With REFRESH_CYCLES=0 → no further frames.
- rstn low at bit 40 → all outputs at reset values within the same cycle, without a clk edge. After release a full 64-bit frame is sent starting at bit 63.
- SEGLED_BLINK_EN, BLINK_LOG2=4, game=10, health=0 → after the frame, seg_pen toggles every 16 cycles and the first byte is C7. Without the macro, seg_pen stays 1.
